// File: rtl/gpio_pio_pkg.sv
// Shared register-map and edge-mode constants for the Avalon GPIO port.
package gpio_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-wide, STAGES-deep flop chain bringing asynchronous pins into clk.
module gpio_sync #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: every stage is reset (not just the last) so a reset leaves no stale
    // pin value in flight to fake an edge once the chain refills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so each stage takes its neighbour's
            // pre-edge value and the chain really is STAGES flops deep.
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/avalon_gpio_pio.sv
// Zero-wait-state Avalon-MM GPIO slave: direction, set/clear output writes,
// synchronised inputs, sticky edge capture and a masked level interrupt.
module avalon_gpio_pio
    import gpio_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISING,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] wr_data;
    logic [31:0]      read_word;
    logic             wr_en;
    logic             unused_writedata;

    assign wr_en   = chipselect & ~write_n;
    assign wr_data = writedata[WIDTH-1:0];
    // Bits above WIDTH are deliberately dropped.
    assign unused_writedata = ^writedata;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_in)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_d <= '0;
        end else begin
            sync_d <= sync_in;
        end
    end

    if (EDGE_TYPE == EDGE_RISING) begin : g_rising
        assign edge_evt = sync_in & ~sync_d;
    end else if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
        assign edge_evt = ~sync_in & sync_d;
    end else begin : g_any
        assign edge_evt = sync_in ^ sync_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_OUT;
            dir      <= RESET_DIR;
            irqmask  <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:    data_out <= wr_data;
                ADDR_DIR:     dir      <= wr_data;
                ADDR_IRQMASK: irqmask  <= wr_data;
                ADDR_OUTSET:  data_out <= data_out | wr_data;
                ADDR_OUTCLR:  data_out <= data_out & ~wr_data;
                default: ;
            endcase
        end
    end

    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? wr_data : '0;

    // A new event is OR-ed in after the clear, so an edge racing a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clr) | edge_evt;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no address leaves read_word unassigned
        // (no inferred latch) and bits above WIDTH read as zero.
        read_word = '0;
        case (address)
            ADDR_DATA:    read_word[WIDTH-1:0] = sync_in;
            ADDR_DIR:     read_word[WIDTH-1:0] = dir;
            ADDR_IRQMASK: read_word[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: read_word[WIDTH-1:0] = edgecap;
            default: ;
        endcase
    end

    assign readdata = read_word;
    assign out_port = data_out;
    assign oe       = dir;
    assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_avalon_gpio_pio.sv
// Three differently-parameterised GPIO instances checked every cycle against a
// behavioural model: directed scenarios first, then randomised bus/pin traffic.
module tb_avalon_gpio_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  cs;
    logic [9:0]  in0, in1;
    logic [31:0] in2;
    logic [31:0] rd0, rd1, rd2;
    logic [9:0]  out0, oe0, out1, oe1;
    logic [31:0] out2, oe2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_gpio_pio #(.WIDTH(10), .RESET_OUT(10'h2A5), .RESET_DIR(10'h000),
                      .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .out_port(out0), .oe(oe0), .irq(irq0));

    avalon_gpio_pio #(.WIDTH(10), .RESET_OUT(10'h000), .RESET_DIR(10'h000),
                      .EDGE_TYPE(2), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .out_port(out1), .oe(oe1), .irq(irq1));

    avalon_gpio_pio #(.WIDTH(32), .RESET_OUT(32'hDEAD_BEEF), .RESET_DIR(32'h0000_00FF),
                      .EDGE_TYPE(1), .SYNC_STAGES(4)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in2), .out_port(out2), .oe(oe2), .irq(irq2));

    // Reference model: per-instance configuration and architectural state.
    logic [31:0] wm      [3] = '{32'h0000_03FF, 32'h0000_03FF, 32'hFFFF_FFFF};
    int          depth   [3] = '{2, 3, 4};
    int          etype   [3] = '{0, 2, 1};
    logic [31:0] rst_out [3] = '{32'h2A5, 32'h0, 32'hDEAD_BEEF};
    logic [31:0] rst_dir [3] = '{32'h0, 32'h0, 32'h0000_00FF};
    logic [31:0] m_out [3];
    logic [31:0] m_dir [3];
    logic [31:0] m_mask[3];
    logic [31:0] m_cap [3];
    // hist[i][k] = pin value sampled k+1 clock edges ago (pin delay line).
    logic [31:0] hist  [3][5];

    function automatic logic [31:0] pin(int i);
        case (i)
            0:       return {22'd0, in0};
            1:       return {22'd0, in1};
            default: return in2;
        endcase
    endfunction

    function automatic logic [31:0] m_read(int i, logic [2:0] a);
        case (a)
            3'd0:    return hist[i][depth[i]-1];
            3'd1:    return m_dir[i];
            3'd2:    return m_mask[i];
            3'd3:    return m_cap[i];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_evt(int i);
        logic [31:0] cur, prev;
        cur  = hist[i][depth[i]-1];
        prev = hist[i][depth[i]];
        case (etype[i])
            0:       return cur & ~prev & wm[i];
            1:       return ~cur & prev & wm[i];
            default: return (cur ^ prev) & wm[i];
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_out[i]  = rst_out[i] & wm[i];
            m_dir[i]  = rst_dir[i] & wm[i];
            m_mask[i] = 32'h0;
            m_cap[i]  = 32'h0;
            for (int k = 0; k < 5; k++) hist[i][k] = 32'h0;
        end
    endtask

    // Applies one rising clock edge to the model using the pre-edge inputs.
    task automatic model_edge();
        logic [31:0] evt, clr, wd;
        if (!reset_n) return;
        for (int i = 0; i < 3; i++) begin
            evt = m_evt(i);
            clr = 32'h0;
            wd  = writedata & wm[i];
            if (cs[i] && !write_n) begin
                case (address)
                    3'd0: m_out[i]  = wd;
                    3'd1: m_dir[i]  = wd;
                    3'd2: m_mask[i] = wd;
                    3'd3: clr       = wd;
                    3'd4: m_out[i]  = m_out[i] | wd;
                    3'd5: m_out[i]  = m_out[i] & ~wd;
                    default: ;
                endcase
            end
            m_cap[i] = (m_cap[i] & ~clr) | evt;
            for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = pin(i) & wm[i];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out0", {22'd0, out0}, m_out[0]);
        check("oe0",  {22'd0, oe0},  m_dir[0]);
        check("irq0", {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
        check("rd0",  rd0, m_read(0, address));
        check("out1", {22'd0, out1}, m_out[1]);
        check("oe1",  {22'd0, oe1},  m_dir[1]);
        check("irq1", {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
        check("rd1",  rd1, m_read(1, address));
        check("out2", out2, m_out[2]);
        check("oe2",  oe2,  m_dir[2]);
        check("irq2", {31'd0, irq2}, {31'd0, |(m_cap[2] & m_mask[2])});
        check("rd2",  rd2, m_read(2, address));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic bus_write(input int i, input logic [2:0] a, input logic [31:0] d);
        cs        = 3'b001 << i;
        address   = a;
        write_n   = 1'b0;
        writedata = d;
        step(1);
        cs      = 3'b000;
        write_n = 1'b1;
    endtask

    task automatic read_check(input int i, input logic [2:0] a, input string tag,
                              input logic [31:0] exp);
        cs      = 3'b001 << i;
        address = a;
        write_n = 1'b1;
        #1;
        case (i)
            0:       check(tag, rd0, exp);
            1:       check(tag, rd1, exp);
            default: check(tag, rd2, exp);
        endcase
        cs = 3'b000;
    endtask

    initial begin
        reset_n   = 1'b0;
        cs        = 3'b000;
        address   = 3'd0;
        write_n   = 1'b1;
        writedata = 32'h0;
        in0       = '0;
        in1       = '0;
        in2       = '0;
        model_reset();
        #12;
        check_all();
        check("rst_out0", {22'd0, out0}, 32'h2A5);
        check("rst_oe2", oe2, 32'h0000_00FF);
        read_check(0, 3'd0, "rst_data0", 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(2);

        // Set/clear on instance 0.
        bus_write(0, 3'd0, 32'h00F);
        bus_write(0, 3'd4, 32'h300);
        bus_write(0, 3'd5, 32'h003);
        check("setclr", {22'd0, out0}, 32'h30C);
        read_check(0, 3'd4, "outset_rd", 32'h0);
        read_check(0, 3'd5, "outclr_rd", 32'h0);

        // Rising capture, two-stage synchroniser.
        in0[3] = 1'b1;
        step(2);
        read_check(0, 3'd3, "cap_early", 32'h0);
        step(1);
        read_check(0, 3'd3, "cap_rise", 32'h8);
        check("irq_unmasked", {31'd0, irq0}, 32'h0);
        bus_write(0, 3'd2, 32'h008);
        check("irq_masked", {31'd0, irq0}, 32'h1);

        // Clear racing a fresh rising edge on the same bit.
        in0[3] = 1'b0;
        step(4);
        in0[3] = 1'b1;
        step(2);
        bus_write(0, 3'd3, 32'h008);
        read_check(0, 3'd3, "race_cap", 32'h8);
        check("race_irq", {31'd0, irq0}, 32'h1);
        bus_write(0, 3'd3, 32'h008);
        read_check(0, 3'd3, "clr_cap", 32'h0);
        check("clr_irq", {31'd0, irq0}, 32'h0);

        // Any-edge mode, three-stage synchroniser.
        in1[0] = 1'b1;
        step(3);
        read_check(1, 3'd3, "any_early", 32'h0);
        step(1);
        read_check(1, 3'd3, "any_rise", 32'h1);
        bus_write(1, 3'd3, 32'h1);
        read_check(1, 3'd3, "any_clr", 32'h0);
        in1[0] = 1'b0;
        step(4);
        read_check(1, 3'd3, "any_fall", 32'h1);

        // Full-width instance, reserved address and deselected write.
        bus_write(2, 3'd1, 32'hFFFF_0000);
        check("dir32", oe2, 32'hFFFF_0000);
        bus_write(2, 3'd2, 32'h0F0F_0000);
        bus_write(2, 3'd6, 32'hFFFF_FFFF);
        cs        = 3'b000;
        address   = 3'd0;
        write_n   = 1'b0;
        writedata = 32'h1234_5678;
        step(1);
        write_n = 1'b1;
        check("resv_out", out2, 32'hDEAD_BEEF);
        check("resv_oe", oe2, 32'hFFFF_0000);
        read_check(2, 3'd6, "resv_rd", 32'h0);
        for (int a = 0; a < 8; a++) read_check(2, 3'(a), "map_rd", m_read(2, 3'(a)));

        // Asynchronous reset mid-operation with a pin edge in flight.
        in0[5] = 1'b1;
        step(1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("midrst_out0", {22'd0, out0}, 32'h2A5);
        @(negedge clk);
        reset_n = 1'b1;
        step(6);

        // Randomised bus and pin traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) in0 = 10'($urandom);
            if ($urandom_range(0, 3) == 0) in1 = 10'($urandom);
            if ($urandom_range(0, 3) == 0) in2 = $urandom;
            cs        = ($urandom_range(0, 4) == 0) ? 3'b000 : (3'b001 << $urandom_range(0, 2));
            address   = 3'($urandom_range(0, 7));
            write_n   = 1'($urandom_range(0, 1));
            writedata = $urandom;
            #1;
            check_all();
            step(1);
        end
        cs      = 3'b000;
        write_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
